// File: rtl/variable_pkg.sv
// Shared definitions for the particle controller: player encoding,
// sprite size and the shot FSM state type.
package variable_pkg;

    localparam logic PLAYER_1 = 1'b0;
    localparam logic PLAYER_2 = 1'b1;

    localparam int PARTICLE_WIDTH  = 64;
    localparam int PARTICLE_HEIGHT = 64;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        FLIGHT,
        IMPACT
    } state_t;

endpackage

// File: rtl/particle_ctl_vblnk_edge.sv
// vblnk_edge: turns the VGA vertical-blank level into a one-cycle frame
// tick on each rising edge. The tick is registered, so it appears one
// cycle after vblnk is first seen high.
module vblnk_edge (
    input  logic clk60MHz,
    input  logic rst_n,
    input  logic vblnk,
    output logic tick
);

    logic vblnk_prev;

    // Remember last vblnk level and emit a registered rising-edge pulse.
    // NOTE: clocked state uses non-blocking (<=) so every register samples pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk60MHz or negedge rst_n) begin
        if (!rst_n) begin
            vblnk_prev <= 1'b0;
            tick       <= 1'b0;
        end else begin
            vblnk_prev <= vblnk;
            tick       <= vblnk & ~vblnk_prev;
        end
    end

endmodule

// File: rtl/particle_ctl.sv
// particle_ctl: launches, flies and lands one particle per turn between
// two players. Position advances only on frame ticks; every output is
// registered one cycle after the internal state it reflects.
// Optional feature: define PARTICLE_WIND_EN to add a signed 4-bit wind
// port whose value is added to x on every flight tick.
module particle_ctl
    import variable_pkg::*;
#(
    parameter int START_X1      = 100,
    parameter int START_X2      = 900,
    parameter int START_Y       = 500,
    parameter int GROUND_Y      = 700,
    parameter int SCREEN_W      = 1024,
    parameter int GRAVITY       = 1,
    parameter int IMPACT_FRAMES = 30
) (
    input  logic        clk60MHz,
    input  logic        rst_n,
    input  logic        vblnk,
    input  logic        throw,
    input  logic [6:0]  power,
`ifdef PARTICLE_WIND_EN
    input  logic [3:0]  wind,
`endif
    output logic [11:0] xpos_particle,
    output logic [11:0] ypos_particle,
    output logic        turn,
    output logic        active,
    output logic        done
);

    localparam int CW = $clog2(IMPACT_FRAMES + 1);

    localparam logic signed [12:0] SX1   = 13'(START_X1);
    localparam logic signed [12:0] SX2   = 13'(START_X2);
    localparam logic signed [12:0] SY    = 13'(START_Y);
    localparam logic signed [12:0] GY    = 13'(GROUND_Y);
    localparam logic signed [12:0] X_MAX = 13'(SCREEN_W - PARTICLE_WIDTH);
    localparam logic signed [12:0] GRAV  = 13'(GRAVITY);
    localparam logic [CW-1:0]      CNT_LAST = CW'(IMPACT_FRAMES - 1);

    logic tick;

    state_t state, state_nxt;

    logic signed [12:0] x, y, vx, vy;
    logic signed [12:0] x_nxt, y_nxt, vx_nxt, vy_nxt;
    logic signed [12:0] step_x, step_y;
    logic [CW-1:0]      cnt, cnt_nxt;
    logic               turn_nxt, done_nxt, hit;

    vblnk_edge u_vblnk_edge (
        .clk60MHz (clk60MHz),
        .rst_n    (rst_n),
        .vblnk    (vblnk),
        .tick     (tick)
    );

    // State register plus shot datapath (position, velocity, hold counter, turn).
    always_ff @(posedge clk60MHz or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            x     <= SX1;
            y     <= SY;
            vx    <= '0;
            vy    <= '0;
            cnt   <= '0;
            turn  <= PLAYER_1;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            x     <= x_nxt;
            y     <= y_nxt;
            vx    <= vx_nxt;
            vy    <= vy_nxt;
            cnt   <= cnt_nxt;
            turn  <= turn_nxt;
            done  <= done_nxt;
        end
    end

    // Next-state and datapath: launch, per-tick trajectory, clamping, impact hold.
    // NOTE: every signal driven here gets a default first, so no path can leave one unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        x_nxt     = x;
        y_nxt     = y;
        vx_nxt    = vx;
        vy_nxt    = vy;
        cnt_nxt   = cnt;
        turn_nxt  = turn;
        done_nxt  = 1'b0;
        hit       = 1'b0;

        step_x = (turn == PLAYER_1) ? (x + vx) : (x - vx);
`ifdef PARTICLE_WIND_EN
        step_x = step_x + {{9{wind[3]}}, wind};
`endif
        step_y = y + vy;

        case (state)
            IDLE: begin
                x_nxt = (turn == PLAYER_1) ? SX1 : SX2;
                y_nxt = SY;
                if (throw) begin
                    state_nxt = ARMED;
                    vx_nxt    = 13'(power >> 2);
                    vy_nxt    = -13'(power >> 1);
                end
            end

            ARMED: begin
                if (tick) state_nxt = FLIGHT;
            end

            FLIGHT: begin
                if (tick) begin
                    x_nxt  = step_x;
                    y_nxt  = step_y;
                    vy_nxt = vy + GRAV;
                    if (step_x < 13'sd0) begin
                        x_nxt = '0;
                        hit   = 1'b1;
                    end else if (step_x > X_MAX) begin
                        x_nxt = X_MAX;
                        hit   = 1'b1;
                    end
                    if (step_y >= GY) begin
                        y_nxt = GY;
                        hit   = 1'b1;
                    end
                    if (hit) begin
                        state_nxt = IMPACT;
                        cnt_nxt   = '0;
                    end
                end
            end

            IMPACT: begin
                if (tick) begin
                    if (cnt == CNT_LAST) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                        turn_nxt  = ~turn;
                        // Preload the next player's launch point so outputs settle a cycle sooner.
                        x_nxt     = (turn == PLAYER_1) ? SX2 : SX1;
                        y_nxt     = SY;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

    // Registered view of the particle: y saturates at 0 and the sprite hides above the screen.
    always_ff @(posedge clk60MHz or negedge rst_n) begin
        if (!rst_n) begin
            xpos_particle <= 12'(START_X1);
            ypos_particle <= 12'(START_Y);
            active        <= 1'b0;
        end else begin
            xpos_particle <= x[11:0];
            ypos_particle <= y[12] ? 12'd0 : y[11:0];
            active        <= (state != IDLE) && !y[12];
        end
    end

endmodule

// File: tb/tb_particle_ctl.sv
// Scoreboard bench for particle_ctl: stimulus queues the expected
// post-frame outputs, a monitor compares them once each frame settles.
module tb_particle_ctl;
    import variable_pkg::*;

    logic        clk60MHz = 1'b0;
    logic        rst_n;
    logic        vblnk;
    logic        throw;
    logic [6:0]  power;
`ifdef PARTICLE_WIND_EN
    logic [3:0]  wind;
`endif
    logic [11:0] xpos_particle;
    logic [11:0] ypos_particle;
    logic        turn;
    logic        active;
    logic        done;

    always #5 clk60MHz = ~clk60MHz;

    particle_ctl dut (
        .clk60MHz      (clk60MHz),
        .rst_n         (rst_n),
        .vblnk         (vblnk),
        .throw         (throw),
        .power         (power),
`ifdef PARTICLE_WIND_EN
        .wind          (wind),
`endif
        .xpos_particle (xpos_particle),
        .ypos_particle (ypos_particle),
        .turn          (turn),
        .active        (active),
        .done          (done)
    );

    typedef struct {
        string tag;
        int    fno;
        int    x;
        int    y;
        logic  turn;
        logic  act;
        int    dones;
    } exp_t;

    exp_t exp_q[$];

    int n_tests   = 0;
    int n_fail    = 0;
    int fno       = 0;
    int mon_fno   = 0;
    int done_cnt  = 0;
    int done_long = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        n_tests++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    // Queue what the outputs must show once the next frame has been processed.
    task automatic expect_frame(input string tag, input int x, input int y,
                                input logic t, input logic a, input int d);
        exp_t e;
        e.tag = tag; e.fno = fno + 1; e.x = x; e.y = y;
        e.turn = t; e.act = a; e.dones = d;
        exp_q.push_back(e);
    endtask

    // One video frame: vblnk high 2 cycles, low 6 cycles.
    task automatic frame();
        fno++;
        vblnk = 1'b1;
        repeat (2) @(negedge clk60MHz);
        vblnk = 1'b0;
        repeat (6) @(negedge clk60MHz);
    endtask

    task automatic pulse_throw();
        throw = 1'b1;
        repeat (2) @(negedge clk60MHz);
        throw = 1'b0;
    endtask

    // Closed-form height after n flight ticks from START_Y with launch speed v0.
    function automatic int fly_y(input int v0, input int n);
        return 500 - v0 * n + (n * (n - 1)) / 2;
    endfunction

    // Count done pulses and any that last longer than one cycle.
    initial begin
        logic done_prev;
        done_prev = 1'b0;
        forever begin
            @(negedge clk60MHz);
            if (done === 1'b1) done_cnt++;
            if (done === 1'b1 && done_prev === 1'b1) done_long++;
            done_prev = done;
        end
    end

    // Monitor: after each frame settles, pop and compare its expectations.
    initial begin
        exp_t e;
        forever begin
            @(posedge vblnk);
            mon_fno++;
            repeat (4) @(negedge clk60MHz);
            while (exp_q.size() > 0 && exp_q[0].fno <= mon_fno) begin
                e = exp_q.pop_front();
                check($sformatf("%s f%0d fno", e.tag, mon_fno), e.fno, mon_fno);
                check($sformatf("%s f%0d x", e.tag, mon_fno), xpos_particle, e.x);
                check($sformatf("%s f%0d y", e.tag, mon_fno), ypos_particle, e.y);
                check($sformatf("%s f%0d turn", e.tag, mon_fno), turn, e.turn);
                check($sformatf("%s f%0d active", e.tag, mon_fno), active, e.act);
                check($sformatf("%s f%0d dones", e.tag, mon_fno), done_cnt, e.dones);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int yv;
        rst_n = 1'b0;
        vblnk = 1'b0;
        throw = 1'b0;
        power = '0;
`ifdef PARTICLE_WIND_EN
        wind  = '0;
`endif
        repeat (3) @(negedge clk60MHz);
        check("reset x", xpos_particle, 100);
        check("reset y", ypos_particle, 500);
        check("reset turn", turn, PLAYER_1);
        check("reset active", active, 0);
        check("reset done", done, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk60MHz);

        // Shot 1: player 1, power 32 -> vx=8, vy=-16, lands on tick 43.
        power = 7'd32;
        pulse_throw();
        expect_frame("p1 arm", 100, 500, PLAYER_1, 1'b1, 0);
        frame();
        for (int n = 1; n <= 43; n++) begin
            yv = fly_y(16, n);
            if (yv > 700) yv = 700;
            expect_frame("p1 flight", 100 + 8 * n, yv, PLAYER_1, 1'b1, 0);
            frame();
        end
        for (int m = 1; m <= 30; m++) begin
            if (m < 30) expect_frame("p1 impact", 444, 700, PLAYER_1, 1'b1, 0);
            else        expect_frame("p1 end", 900, 500, PLAYER_2, 1'b0, 1);
            frame();
        end

        // Shot 2: player 2, power 127, throw held and power changed mid-flight.
        power = 7'd127;
        throw = 1'b1;
        repeat (2) @(negedge clk60MHz);
        expect_frame("p2 arm", 900, 500, PLAYER_2, 1'b1, 1);
        frame();
        power = 7'd4;
        for (int n = 1; n <= 30; n++) begin
            yv = fly_y(63, n);
            expect_frame("p2 flight", (n == 30) ? 0 : 900 - 31 * n,
                         (yv < 0) ? 0 : yv, PLAYER_2, (yv >= 0), 1);
            frame();
        end
        for (int m = 1; m <= 30; m++) begin
            if (m == 16) throw = 1'b0;
            if (m < 30) expect_frame("p2 impact", 0, 0, PLAYER_2, 1'b0, 1);
            else        expect_frame("p2 end", 100, 500, PLAYER_1, 1'b0, 2);
            frame();
        end
        expect_frame("idle no relaunch", 100, 500, PLAYER_1, 1'b0, 2);
        frame();

        // Shot 3: player 1, reset at flight tick 10 aborts without done.
        power = 7'd32;
        pulse_throw();
        expect_frame("p1b arm", 100, 500, PLAYER_1, 1'b1, 2);
        frame();
        for (int n = 1; n <= 10; n++) begin
            expect_frame("p1b flight", 100 + 8 * n, fly_y(16, n), PLAYER_1, 1'b1, 2);
            frame();
        end
        rst_n = 1'b0;
        #1;
        check("abort x", xpos_particle, 100);
        check("abort y", ypos_particle, 500);
        check("abort turn", turn, PLAYER_1);
        check("abort active", active, 0);
        check("abort done", done, 0);
        repeat (3) @(negedge clk60MHz);
        rst_n = 1'b1;
        repeat (2) @(negedge clk60MHz);
        expect_frame("post abort", 100, 500, PLAYER_1, 1'b0, 2);
        frame();

`ifdef PARTICLE_WIND_EN
        // Wind -2 with player 1 power 32: x steps by 8-2=6 per tick.
        wind = 4'hE;
        pulse_throw();
        expect_frame("wind arm", 100, 500, PLAYER_1, 1'b1, 2);
        frame();
        expect_frame("wind t1", 106, 484, PLAYER_1, 1'b1, 2);
        frame();
        expect_frame("wind t2", 112, 469, PLAYER_1, 1'b1, 2);
        frame();
`endif

        repeat (4) @(negedge clk60MHz);
        check("scoreboard drained", exp_q.size(), 0);
        check("done pulse width", done_long, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
